mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multi-cycle control unit for the RV32I-subset CPU.
- Sits upstream of the datapath (PC, IR, register file, ALU, memory port). It consumes the decoded instruction fields and the ALU zero flag, and drives every datapath enable and mux select, one state per cycle.
- Also keeps cycle and retired-instruction counters for the bench.

Parameters:
- CNT_W, 32, width of cycle_cnt and instr_cnt.
- HALT_ON_ILLEGAL, 1, 1: an unsupported opcode enters HALT; 0: it retires as a NOP.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  data memory has completed the access.
- pc_write  out  1  PC register enable.
- pc_src  out  1  0: ALU result; 1: ALUOut register.
- ir_write  out  1  IR and old_pc latch enable.
- reg_write  out  1  register file write enable.
- mem_read  out  1  data memory read request.
- mem_write  out  1  data memory write request.
- alu_src_a  out  2  0: pc; 1: rs1; 2: old_pc.
- alu_src_b  out  2  0: rs2; 1: imm; 2: constant 4.
- alu_ctrl  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- wb_sel  out  2  0: ALUOut; 1: MDR; 2: pc.
- branch  out  1  a conditional branch is being evaluated (EXE_BR).
- state  out  4  current state encoding.
- halted  out  1  FSM is in HALT.
- cycle_cnt  out  CNT_W  cycles since reset, excluding HALT.
- instr_cnt  out  CNT_W  retired instructions.

Behaviour:
- State encoding: IF=0, ID=1, EX_R=2, EX_I=3, EX_ADDR=4, MEM_LD=5, MEM_ST=6, WB_ALU=7, WB_LD=8, EX_BR=9, EX_JAL=10, HALT=11. Unused codes go to IF on the next edge.
- Reset: rst_n=0 at a clock edge sets state=IF and cycle_cnt=instr_cnt=0. This applies in any state, including mid-MEM wait and HALT. Outputs are then the IF decode.
- Outputs are Moore, decoded from state. pc_write in EX_BR is the only Mealy output. Any output not listed for a state is 0.
- IF:
  - ir_write=1, pc_write=1, pc_src=0, alu_src_a=0, alu_src_b=2, ADD.
  - Next state is ID.
- ID:
  - alu_src_a=2, alu_src_b=1, ADD (precomputes the branch/JAL target into ALUOut).
  - Next state by opcode: 0110011→EX_R; 0010011→EX_I; 0000011 or 0100011→EX_ADDR; 1100011→EX_BR; 1101111→EX_JAL.
  - Any other opcode: HALT if HALT_ON_ILLEGAL=1, else IF and counted as retired.
- EX_R:
  - alu_src_a=1, alu_src_b=0.
  - alu_ctrl from funct3: 000 ADD (SUB if funct7_5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7_5), 110 OR, 111 AND.
  - Next state is WB_ALU.
- EX_I:
  - alu_src_a=1, alu_src_b=1.
  - Same funct3 map as EX_R, except 000 is always ADD; funct7_5 selects SRA only for 101.
  - Next state is WB_ALU.
- EX_ADDR:
  - alu_src_a=1, alu_src_b=1, ADD.
  - Next state is MEM_LD for opcode 0000011, MEM_ST for 0100011.
- MEM_LD:
  - mem_read=1, held while mem_ready=0.
  - Goes to WB_LD on the edge where mem_ready=1. Zero-wait is allowed: mem_ready already 1 on the first cycle means exactly one cycle in the state.
- MEM_ST:
  - mem_write=1, held while mem_ready=0.
  - Goes to IF on the edge where mem_ready=1 (retire).
- WB_ALU: reg_write=1, wb_sel=0; next state IF (retire).
- WB_LD: reg_write=1, wb_sel=1; next state IF (retire).
- EX_BR:
  - branch=1, alu_src_a=1, alu_src_b=0, SUB, pc_src=1.
  - pc_write = zero XOR funct3[0] (BEQ 000 / BNE 001). Other funct3 values are treated by funct3[0] alone.
  - Next state IF (retire).
- EX_JAL:
  - reg_write=1, wb_sel=2 (PC already holds pc+4), pc_write=1, pc_src=1.
  - Next state IF (retire).
- HALT: halted=1, all enables 0; only reset leaves it.
- Latency: R/I 4 cycles, branch 3, JAL 3, SW 4+w, LW 5+w, where w = cycles with mem_ready=0 in MEM.
- Counters:
  - cycle_cnt increments on every edge where the state is not HALT and rst_n=1.
  - instr_cnt increments on every edge that makes a retire transition into IF.
  - Both wrap modulo 2^CNT_W.

Test Plan:
- Reset then add (opcode 0110011, funct3 000, funct7_5 0): states 0,1,2,7,0; reg_write=1 only in cycle 4; alu_ctrl=0 in EX_R; instr_cnt=1, cycle_cnt=4.
- sub (funct7_5=1) and srai (0010011, funct3 101, funct7_5=1): alu_ctrl=1 and 7 respectively; addi with funct7_5=1 gives alu_ctrl=0.
- lw with mem_ready low for 3 cycles: MEM_LD held 4 cycles with mem_read=1, then WB_LD with wb_sel=1; total 8 cycles. sw with mem_ready=1 immediately: 4 cycles, mem_write high exactly 1 cycle, reg_write never high.
- beq, zero=1 → pc_write=1 in EX_BR. bne, zero=1 → pc_write=0. Both take 3 cycles with branch=1 for exactly 1 cycle.
- jal: EX_JAL drives reg_write=1, wb_sel=2, pc_write=1, pc_src=1. Opcode 0000000 with HALT_ON_ILLEGAL=1: HALT at cycle 3 and cycle_cnt frozen; with HALT_ON_ILLEGAL=0: back to IF and instr_cnt+1.
- rst_n=0 during a MEM_LD wait: next edge state=0 and counters=0; the next instruction completes normally.

Source files
------------

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control unit for an RV32I-subset CPU.
// Consumes decoded instruction fields plus the ALU zero flag and drives
// every datapath enable/select, one state per cycle. Also keeps free-running
// cycle and retired-instruction counters.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   opcode/funct3/funct7_5 instruction fields from IR
//   zero, mem_ready       ALU zero flag, data memory completion
//   pc_write, pc_src      PC enable and source (0 ALU result, 1 ALUOut)
//   ir_write              IR / old_pc latch enable
//   reg_write, wb_sel     register file write enable and writeback source
//   mem_read, mem_write   data memory requests
//   alu_src_a/b, alu_ctrl ALU operand selects and operation
//   branch, halted, state status of the FSM
//   cycle_cnt, instr_cnt  cycles since reset (excl. HALT), retired count
module mc_control_fsm #(
    parameter int unsigned CNT_W           = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctrl,
    output logic [1:0]       wb_sel,
    output logic             branch,
    output logic [3:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_EX_R    = 4'd2,
        S_EX_I    = 4'd3,
        S_EX_ADDR = 4'd4,
        S_MEM_LD  = 4'd5,
        S_MEM_ST  = 4'd6,
        S_WB_ALU  = 4'd7,
        S_WB_LD   = 4'd8,
        S_EX_BR   = 4'd9,
        S_EX_JAL  = 4'd10,
        S_HALT    = 4'd11
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    state_t state_q;
    state_t state_d;
    logic   retire;
    logic   is_r_type;
    logic [3:0] alu_fn;

    // funct3 -> ALU op; funct7_5 only qualifies 000 for R-type (SUB)
    // and 101 for both R and I (SRA).
    always_comb begin
        alu_fn = ALU_ADD;
        case (funct3)
            3'b000:  alu_fn = (is_r_type && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_fn = ALU_SLL;
            3'b010:  alu_fn = ALU_SLT;
            3'b011:  alu_fn = ALU_SLTU;
            3'b100:  alu_fn = ALU_XOR;
            3'b101:  alu_fn = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
        endcase
    end

    assign is_r_type = (state_q == S_EX_R);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != S_HALT) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (retire) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = S_IF;
        retire    = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        alu_ctrl  = ALU_ADD;
        wb_sel    = 2'd0;
        branch    = 1'b0;
        halted    = 1'b0;

        case (state_q)
            S_IF: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'd2;
                state_d   = S_ID;
            end
            S_ID: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                case (opcode)
                    OP_R:         state_d = S_EX_R;
                    OP_I:         state_d = S_EX_I;
                    OP_LD, OP_ST: state_d = S_EX_ADDR;
                    OP_BR:        state_d = S_EX_BR;
                    OP_JAL:       state_d = S_EX_JAL;
                    default: begin
                        if (HALT_ON_ILLEGAL) begin
                            state_d = S_HALT;
                        end else begin
                            state_d = S_IF;
                            retire  = 1'b1;
                        end
                    end
                endcase
            end
            S_EX_R: begin
                alu_src_a = 2'd1;
                alu_ctrl  = alu_fn;
                state_d   = S_WB_ALU;
            end
            S_EX_I: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                alu_ctrl  = alu_fn;
                state_d   = S_WB_ALU;
            end
            S_EX_ADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                state_d   = (opcode == OP_ST) ? S_MEM_ST : S_MEM_LD;
            end
            S_MEM_LD: begin
                mem_read = 1'b1;
                state_d  = mem_ready ? S_WB_LD : S_MEM_LD;
            end
            S_MEM_ST: begin
                mem_write = 1'b1;
                state_d   = mem_ready ? S_IF : S_MEM_ST;
                retire    = mem_ready;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_WB_LD: begin
                reg_write = 1'b1;
                wb_sel    = 2'd1;
                retire    = 1'b1;
            end
            S_EX_BR: begin
                branch    = 1'b1;
                alu_src_a = 2'd1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 1'b1;
                // BEQ (funct3[0]=0) takes on zero, BNE on !zero
                pc_write  = zero ^ funct3[0];
                retire    = 1'b1;
            end
            S_EX_JAL: begin
                reg_write = 1'b1;
                wb_sel    = 2'd2;
                pc_write  = 1'b1;
                pc_src    = 1'b1;
                retire    = 1'b1;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_IF;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        zero;
    logic        mem_ready;

    logic        pc_write, pc_src, ir_write, reg_write, mem_read, mem_write;
    logic [1:0]  alu_src_a, alu_src_b, wb_sel;
    logic [3:0]  alu_ctrl, state;
    logic        branch, halted;
    logic [31:0] cycle_cnt, instr_cnt;

    logic        n_pc_write, n_pc_src, n_ir_write, n_reg_write, n_mem_read, n_mem_write;
    logic [1:0]  n_alu_src_a, n_alu_src_b, n_wb_sel;
    logic [3:0]  n_alu_ctrl, n_state;
    logic        n_branch, n_halted;
    logic [31:0] n_cycle_cnt, n_instr_cnt;

    int checks = 0;
    int errors = 0;

    mc_control_fsm #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .wb_sel(wb_sel), .branch(branch), .state(state), .halted(halted),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    mc_control_fsm #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
        .pc_write(n_pc_write), .pc_src(n_pc_src), .ir_write(n_ir_write),
        .reg_write(n_reg_write), .mem_read(n_mem_read), .mem_write(n_mem_write),
        .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_ctrl(n_alu_ctrl),
        .wb_sel(n_wb_sel), .branch(n_branch), .state(n_state), .halted(n_halted),
        .cycle_cnt(n_cycle_cnt), .instr_cnt(n_instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
    endtask

    task automatic test_reset();
        set_instr(7'b0110011, 3'b000, 1'b0);
        do_reset();
        checks++;
        if ({state, cycle_cnt, instr_cnt} !== {4'd0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_state: state=%0d cyc=%0d ins=%0d expected 0 0 0", state, cycle_cnt, instr_cnt);
        end
        checks++;
        if ({ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_ctrl, reg_write, halted} !==
            {1'b1, 1'b1, 1'b0, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_if_decode: ir_w=%b pc_w=%b pc_src=%b a=%0d b=%0d alu=%0d reg_w=%b halt=%b expected 1 1 0 0 2 0 0 0",
                     ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_ctrl, reg_write, halted);
        end
        checks++;
        if ({n_state, n_cycle_cnt, n_instr_cnt} !== {4'd0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_state_nop: state=%0d cyc=%0d ins=%0d expected 0 0 0", n_state, n_cycle_cnt, n_instr_cnt);
        end
    endtask

    task automatic test_add();
        logic [3:0] exp_st [4] = '{4'd1, 4'd2, 4'd7, 4'd0};
        logic       exp_rw [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        set_instr(7'b0110011, 3'b000, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({state, reg_write} !== {exp_st[i], exp_rw[i]}) begin
                errors++;
                $display("FAIL add_seq[%0d]: state=%0d reg_write=%b expected %0d %b", i, state, reg_write, exp_st[i], exp_rw[i]);
            end
            if (i == 1) begin
                checks++;
                if ({alu_ctrl, alu_src_a, alu_src_b} !== {4'd0, 2'd1, 2'd0}) begin
                    errors++;
                    $display("FAIL add_ex_r: alu=%0d a=%0d b=%0d expected 0 1 0", alu_ctrl, alu_src_a, alu_src_b);
                end
            end
            if (i == 2) begin
                checks++;
                if (wb_sel !== 2'd0) begin
                    errors++;
                    $display("FAIL add_wb_sel: got %0d expected 0", wb_sel);
                end
            end
        end
        checks++;
        if ({instr_cnt, cycle_cnt} !== {32'd1, 32'd4}) begin
            errors++;
            $display("FAIL add_counters: instr=%0d cycle=%0d expected 1 4", instr_cnt, cycle_cnt);
        end
    endtask

    task automatic test_alu_decode();
        logic [6:0] ops [14] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
                                 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
                                 7'b0010011, 7'b0010011, 7'b0010011, 7'b0010011};
        logic [2:0] f3s [14] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101,
                                 3'b101, 3'b110, 3'b111, 3'b000, 3'b101, 3'b101, 3'b001};
        logic       f7s [14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0] exp_alu [14] = '{4'd0, 4'd1, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6,
                                     4'd7, 4'd3, 4'd2, 4'd0, 4'd7, 4'd6, 4'd5};
        logic [3:0] exp_st [14] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2,
                                    4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3};
        for (int i = 0; i < 14; i++) begin
            set_instr(ops[i], f3s[i], f7s[i]);
            do_reset();
            tick();
            tick();
            checks++;
            if ({state, alu_ctrl} !== {exp_st[i], exp_alu[i]}) begin
                errors++;
                $display("FAIL alu_decode[%0d]: state=%0d alu_ctrl=%0d expected %0d %0d", i, state, alu_ctrl, exp_st[i], exp_alu[i]);
            end
        end
    endtask

    task automatic test_lw_wait();
        set_instr(7'b0000011, 3'b010, 1'b0);
        mem_ready = 1'b0;
        do_reset();
        tick();
        tick();
        checks++;
        if ({state, alu_src_a, alu_src_b, alu_ctrl} !== {4'd4, 2'd1, 2'd1, 4'd0}) begin
            errors++;
            $display("FAIL lw_ex_addr: state=%0d a=%0d b=%0d alu=%0d expected 4 1 1 0", state, alu_src_a, alu_src_b, alu_ctrl);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) mem_ready = 1'b1;
            checks++;
            if ({state, mem_read} !== {4'd5, 1'b1}) begin
                errors++;
                $display("FAIL lw_mem_wait[%0d]: state=%0d mem_read=%b expected 5 1", i, state, mem_read);
            end
        end
        tick();
        mem_ready = 1'b0;
        checks++;
        if ({state, reg_write, wb_sel, mem_read} !== {4'd8, 1'b1, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL lw_wb: state=%0d reg_write=%b wb_sel=%0d mem_read=%b expected 8 1 1 0", state, reg_write, wb_sel, mem_read);
        end
        tick();
        checks++;
        if ({state, cycle_cnt, instr_cnt} !== {4'd0, 32'd8, 32'd1}) begin
            errors++;
            $display("FAIL lw_latency: state=%0d cycle=%0d instr=%0d expected 0 8 1", state, cycle_cnt, instr_cnt);
        end
    endtask

    task automatic test_sw_zero_wait();
        int mw_cycles = 0;
        int rw_cycles = 0;
        set_instr(7'b0100011, 3'b010, 1'b0);
        mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (mem_write) mw_cycles++;
            if (reg_write) rw_cycles++;
            if (i == 3) begin
                checks++;
                if (state !== 4'd6) begin
                    errors++;
                    $display("FAIL sw_mem_st: state=%0d expected 6", state);
                end
            end
            tick();
        end
        mem_ready = 1'b0;
        checks++;
        if ({mw_cycles, rw_cycles} !== {32'd1, 32'd0}) begin
            errors++;
            $display("FAIL sw_strobes: mem_write_cycles=%0d reg_write_cycles=%0d expected 1 0", mw_cycles, rw_cycles);
        end
        checks++;
        if ({state, cycle_cnt, instr_cnt} !== {4'd0, 32'd4, 32'd1}) begin
            errors++;
            $display("FAIL sw_latency: state=%0d cycle=%0d instr=%0d expected 0 4 1", state, cycle_cnt, instr_cnt);
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3s [4]    = '{3'b000, 3'b001, 3'b000, 3'b001};
        logic       zs [4]     = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       exp_pw [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            int br_cycles = 0;
            set_instr(7'b1100011, f3s[k], 1'b0);
            zero = zs[k];
            do_reset();
            for (int i = 0; i < 3; i++) begin
                if (branch) br_cycles++;
                if (i == 2) begin
                    checks++;
                    if ({state, pc_write, pc_src, alu_ctrl, alu_src_a, alu_src_b} !==
                        {4'd9, exp_pw[k], 1'b1, 4'd1, 2'd1, 2'd0}) begin
                        errors++;
                        $display("FAIL branch_ex[%0d]: state=%0d pc_write=%b pc_src=%b alu=%0d a=%0d b=%0d expected 9 %b 1 1 1 0",
                                 k, state, pc_write, pc_src, alu_ctrl, alu_src_a, alu_src_b, exp_pw[k]);
                    end
                end
                tick();
            end
            checks++;
            if ({br_cycles, state, cycle_cnt, instr_cnt} !== {32'd1, 4'd0, 32'd3, 32'd1}) begin
                errors++;
                $display("FAIL branch_seq[%0d]: branch_cycles=%0d state=%0d cycle=%0d instr=%0d expected 1 0 3 1",
                         k, br_cycles, state, cycle_cnt, instr_cnt);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        set_instr(7'b1101111, 3'b000, 1'b0);
        do_reset();
        tick();
        tick();
        checks++;
        if ({state, reg_write, wb_sel, pc_write, pc_src, ir_write} !== {4'd10, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL jal_ex: state=%0d reg_write=%b wb_sel=%0d pc_write=%b pc_src=%b ir_write=%b expected 10 1 2 1 1 0",
                     state, reg_write, wb_sel, pc_write, pc_src, ir_write);
        end
        tick();
        checks++;
        if ({state, cycle_cnt, instr_cnt} !== {4'd0, 32'd3, 32'd1}) begin
            errors++;
            $display("FAIL jal_latency: state=%0d cycle=%0d instr=%0d expected 0 3 1", state, cycle_cnt, instr_cnt);
        end
    endtask

    task automatic test_illegal();
        set_instr(7'b0000000, 3'b000, 1'b0);
        do_reset();
        tick();
        tick();
        checks++;
        if ({state, halted, pc_write, ir_write, reg_write, cycle_cnt} !== {4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 32'd2}) begin
            errors++;
            $display("FAIL halt_enter: state=%0d halted=%b pc_w=%b ir_w=%b reg_w=%b cycle=%0d expected 11 1 0 0 0 2",
                     state, halted, pc_write, ir_write, reg_write, cycle_cnt);
        end
        checks++;
        if ({n_state, n_halted, n_instr_cnt, n_cycle_cnt} !== {4'd0, 1'b0, 32'd1, 32'd2}) begin
            errors++;
            $display("FAIL illegal_nop: state=%0d halted=%b instr=%0d cycle=%0d expected 0 0 1 2",
                     n_state, n_halted, n_instr_cnt, n_cycle_cnt);
        end
        set_instr(7'b0110011, 3'b000, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if ({state, halted, cycle_cnt, instr_cnt} !== {4'd11, 1'b1, 32'd2, 32'd0}) begin
            errors++;
            $display("FAIL halt_frozen: state=%0d halted=%b cycle=%0d instr=%0d expected 11 1 2 0",
                     state, halted, cycle_cnt, instr_cnt);
        end
        do_reset();
        checks++;
        if ({state, halted, cycle_cnt} !== {4'd0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL halt_reset: state=%0d halted=%b cycle=%0d expected 0 0 0", state, halted, cycle_cnt);
        end
    endtask

    task automatic test_reset_mid_mem();
        set_instr(7'b0000011, 3'b010, 1'b0);
        mem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if ({state, cycle_cnt} !== {4'd5, 32'd5}) begin
            errors++;
            $display("FAIL mid_mem_pre: state=%0d cycle=%0d expected 5 5", state, cycle_cnt);
        end
        do_reset();
        checks++;
        if ({state, cycle_cnt, instr_cnt, mem_read} !== {4'd0, 32'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_mem_reset: state=%0d cycle=%0d instr=%0d mem_read=%b expected 0 0 0 0",
                     state, cycle_cnt, instr_cnt, mem_read);
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        mem_ready = 1'b0;
        checks++;
        if ({state, cycle_cnt, instr_cnt} !== {4'd0, 32'd5, 32'd1}) begin
            errors++;
            $display("FAIL mid_mem_after: state=%0d cycle=%0d instr=%0d expected 0 5 1", state, cycle_cnt, instr_cnt);
        end
    endtask

    task automatic test_back_to_back();
        set_instr(7'b0010011, 3'b000, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        set_instr(7'b1101111, 3'b000, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        set_instr(7'b1100011, 3'b001, 1'b0);
        zero = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        zero = 1'b0;
        checks++;
        if ({state, cycle_cnt, instr_cnt} !== {4'd0, 32'd10, 32'd3}) begin
            errors++;
            $display("FAIL back_to_back: state=%0d cycle=%0d instr=%0d expected 0 10 3", state, cycle_cnt, instr_cnt);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = '0;
        funct3    = '0;
        funct7_5  = 1'b0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        #2;
        test_reset();
        test_add();
        test_alu_decode();
        test_lw_wait();
        test_sw_zero_wait();
        test_branch();
        test_jal();
        test_illegal();
        test_reset_mid_mem();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
